uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- UART transmit stage that sits directly downstream of the team's first-word-fall-through TX byte FIFO.
- Pops one byte whenever the FIFO is non-empty and serialises it on a single line: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
- Contains its own bit-period counter, so no external baud tick is needed.
- Sends back-to-back frames with zero idle gap while the FIFO has data.

Parameters:
- DATA_W, 8, data bits per frame; must match the FIFO data width.
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200); legal range 2..65535.
- STOP_BITS, 1, number of stop bits; only 1 or 2 is legal.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- fifo_data  input  DATA_W  head-of-FIFO word; valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  pop strobe to the FIFO; registered; high for exactly one cycle per byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high from the first start-bit cycle until the final stop-bit period completes.
- tx_done  output  1  one-cycle pulse on the last cycle of each frame's final stop bit.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low on reset_n.
- Reset values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, bit timer=0, bit index=0, shift register=0.
- States:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0].
  - PARITY: present only with the macro.
  - STOP: tx=1.
- Bit timer counts 0..CLKS_PER_BIT-1. bit_end = (timer==CLKS_PER_BIT-1). Timer resets to 0 on every bit_end and on every load.
- Load event occurs on the rising edge where (state==IDLE, or state==STOP with bit_end on the last stop bit) and fifo_empty==0. On that edge:
  - shift <= fifo_data; parity register <= ^fifo_data ^ PARITY_ODD.
  - fifo_rd_en <= 1, dropping to 0 on the next edge.
  - state <= START, tx <= 0, busy <= 1.
- Latency: tx falls on the first edge at which fifo_empty=0 is sampled in IDLE.
- The FIFO's fifo_data and fifo_empty are not sampled outside load events.
- Transitions:
  - START, on bit_end -> DATA, bit index=0.
  - DATA, on bit_end: shift right by one, index+1. At index DATA_W-1 -> PARITY if enabled, else STOP.
  - PARITY, on bit_end -> STOP.
  - STOP: lasts STOP_BITS bit periods.
- End of the final stop bit: tx_done pulses on that cycle. Next state is START (load event) if fifo_empty=0, else IDLE with busy <= 0.
- Frame length: (1 + DATA_W + parity + STOP_BITS) x CLKS_PER_BIT cycles exactly; no idle gap between back-to-back frames.
- fifo_rd_en never asserts while fifo_empty=1.
- Reset mid-frame: tx returns to 1 immediately (asynchronous). The in-flight byte is abandoned; it was already popped.
- Width rules:
  - Timer width = $clog2(CLKS_PER_BIT).
  - Bit index width = $clog2(DATA_W).
  - No arithmetic overflow is allowed; the counters wrap only via explicit reset to 0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA, and tx = stored parity bit for one bit period. Parity bit = even (XOR of data) when PARITY_ODD=0, inverted when PARITY_ODD=1.
- Undefined: no PARITY state and no parity register; PARITY_ODD is ignored; DATA goes straight to STOP.

Decomposition:
- Package uart_pkg holds:
  - tx state encoding constants: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - START_BIT=1'b0, STOP_BIT=1'b1.
  - default CLKS_PER_BIT.
- The package is shared with the future RX block.
- One sub-module: uart_bit_timer. Parameter CLKS_PER_BIT; inputs clk, reset_n, clear; output bit_end. Reused by RX.

Test Plan (CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1, no parity unless noted):
1. Reset held low with fifo_empty=0 -> tx=1, fifo_rd_en=0, busy=0, tx_done=0 throughout.
2. FIFO holds 0x55, empty deasserts -> one fifo_rd_en pulse on the same edge tx falls. tx sequence is 0,1,0,1,0,1,0,1,0,1, 4 cycles each (40 cycles). tx_done pulses on cycle 40. busy drops on the following cycle.
3. FIFO holds 0xA5 then 0x3C -> second fifo_rd_en exactly 40 cycles after the first; no high gap between the frames. Decoded LSB-first bits are 1,0,1,0,0,1,0,1 and 0,0,1,1,1,1,0,0.
4. fifo_empty=1 for 200 cycles -> tx stays 1, fifo_rd_en never asserts.
5. reset_n pulsed low at cycle 13 of a 0xFF frame -> tx=1 asynchronously, state IDLE. After release, the next FIFO byte transmits with a full start bit.
6. UART_TX_PARITY_EN defined, PARITY_ODD=0, STOP_BITS=2, byte 0x07 -> parity bit 1. Frame is 12 bits = 48 cycles; tx_done pulses on cycle 48.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, line levels and the default
// bit period. Used by the TX serializer and the future RX block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 50 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Restarts from 0 on clear or after each bit_end.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_LAST);

  // Free-running period counter; wraps only by explicit return to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter fed by a first-word-fall-through byte FIFO. Frames are
// start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop
// bits, sent back to back while the FIFO holds data.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  // Index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic STOP_LAST = (STOP_BITS == 2);

  tx_state_e         state, state_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic              stop_idx, stop_idx_d;
  logic              tx_d, busy_d, rd_en_d;
  logic              bit_end, frame_end, load, timer_clear;

`ifdef UART_TX_PARITY_EN
  logic par, par_d;
`else
  // Parity sense has no effect without the parity bit.
  logic parity_odd_unused;
  assign parity_odd_unused = (PARITY_ODD != 0);
`endif

  // Last cycle of the final stop bit; a waiting byte is loaded on this edge.
  assign frame_end   = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  assign load        = !fifo_empty && ((state == IDLE) || frame_end);
  assign timer_clear = load || (state == IDLE);
  assign tx_done     = frame_end;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .bit_end (bit_end)
  );

  // Next-state and next-output logic; tx is registered so the line is glitch-free.
  always_comb begin
    state_d    = state;
    shift_d    = shift;
    idx_d      = idx;
    stop_idx_d = stop_idx;
    tx_d       = tx;
    busy_d     = busy;
    rd_en_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par;
`endif
    if (load) begin
      state_d    = START;
      shift_d    = fifo_data;
      idx_d      = '0;
      stop_idx_d = 1'b0;
      tx_d       = START_BIT;
      busy_d     = 1'b1;
      rd_en_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_d      = (^fifo_data) ^ (PARITY_ODD != 0);
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_d   = STOP_BIT;
          busy_d = 1'b0;
        end
        START: begin
          if (bit_end) begin
            state_d = DATA;
            idx_d   = '0;
            tx_d    = shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift_d = shift >> 1;
            if (idx == IDX_LAST) begin
              idx_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = par;
`else
              state_d    = STOP;
              stop_idx_d = 1'b0;
              tx_d       = STOP_BIT;
`endif
            end else begin
              idx_d = idx + 1'b1;
              tx_d  = shift_d[0];
            end
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (bit_end) begin
            state_d    = STOP;
            stop_idx_d = 1'b0;
            tx_d       = STOP_BIT;
          end
`else
          // Unreachable without parity; fall back to a quiet line.
          state_d = IDLE;
          tx_d    = STOP_BIT;
          busy_d  = 1'b0;
`endif
        end
        STOP: begin
          if (bit_end) begin
            if (stop_idx == STOP_LAST) begin
              state_d = IDLE;
              tx_d    = STOP_BIT;
              busy_d  = 1'b0;
            end else begin
              stop_idx_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = STOP_BIT;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs; reset drops the frame and idles the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      stop_idx   <= 1'b0;
      tx         <= STOP_BIT;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      idx        <= idx_d;
      stop_idx   <= stop_idx_d;
      tx         <= tx_d;
      busy       <= busy_d;
      fifo_rd_en <= rd_en_d;
`ifdef UART_TX_PARITY_EN
      par        <= par_d;
`endif
    end
  end

endmodule
